// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling,
// configurable data width / parity / stop bits, and a held-valid output
// with parity, framing and overrun flags for a ready/clear consumer.
module uart_rx_param #(
  parameter int CLK_FRQ_HZ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_clear,
  output logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CPB  = CLK_FRQ_HZ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE, S_BRK
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  // Receive FSM. cnt restarts at start detection and at every sample, so each
  // sample instant is a fixed offset from the start edge (no drift tracking).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_ready   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Consumer acknowledge; in DONE the incoming frame takes priority below.
      if (rx_clear && state != S_DONE) begin
        rx_ready   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      cnt <= cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= S_START;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            state <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == CPB_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end
          end
        end
        S_PAR: begin
          if (cnt == CPB_LAST) begin
            cnt   <= '0;
            perr  <= (PARITY == 1) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt == CPB_LAST) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (!rx_s) ferr <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          cnt <= '0;
          if (!rx_ready || rx_clear) begin
            rx_data    <= shreg;
            rx_ready   <= 1'b1;
            parity_err <= perr;
            frame_err  <= ferr;
            overrun    <= 1'b0;
          end else begin
            overrun <= 1'b1;
          end
          state <= ferr ? S_BRK : S_IDLE;
        end
        S_BRK: begin
          // Hold off until the line returns high so a break is one frame.
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
